pulse_req_queue: RTL and testbench
==================================

PULSE_REQ_QUEUE -- requirements
Module: pulse_req_queue

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-event counter; maximum pending is 2^CNT_W-1.
REQ-002 Parameter TMO, default 4: number of cycles allowed in WAIT_HI before a timeout is declared; range 1..255.
REQ-003 src_clkA  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 rstA  input  1  reset; synchronous and active-high.
REQ-005 event_in  input  1  single-cycle source event; each cycle high counts as one event.
REQ-006 busy  input  1  busy from the downstream handshake pulse synchronizer.
REQ-007 ovf_clr  input  1  clears the overflow flag.
REQ-008 sinput  output  1  registered one-cycle request pulse to the synchronizer.
REQ-009 pending  output  CNT_W  current number of queued events.
REQ-010 overflow  output  1  sticky flag: an event was dropped.
REQ-011 tmo_err  output  1  sticky flag: busy did not rise after a pulse; cleared only by reset.
REQ-012 idle  output  1  high when state is IDLE and pending is 0.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-014 IDLE -> ISSUE when pending>0 and busy==0 (values of the current cycle); otherwise stay in IDLE.
REQ-015 ISSUE: sinput=1 for exactly this one cycle; pending decrements on the edge entering ISSUE; next state WAIT_HI.
REQ-016 WAIT_HI: busy==1 -> WAIT_LO; timeout counter reaching TMO cycles without busy -> set tmo_err, go to IDLE.
REQ-017 WAIT_LO: busy==0 -> IDLE; no timeout applies.
REQ-018 sinput is 0 in every state other than ISSUE; two sinput pulses are always separated by at least one busy high-to-low cycle or one timeout.
REQ-019 Latency: event_in in cycle t, with IDLE, pending 0 and busy 0 -> pending=1 in t+1, sinput=1 in t+2.
REQ-020 Simultaneous event_in and decrement (the edge into ISSUE): pending unchanged.
REQ-021 Full: event_in while pending==2^CNT_W-1 and no simultaneous decrement -> event dropped, pending held, overflow set next cycle.
REQ-022 Full with simultaneous decrement: event accepted, pending unchanged, overflow not set.
REQ-023 overflow set and ovf_clr in the same cycle: set wins.
REQ-024 pending never wraps below 0 or above its maximum.

Reset
REQ-025 rstA high at a rising edge -> state IDLE, pending 0, sinput 0, overflow 0, tmo_err 0, timeout counter 0; idle=1 in the following cycle.
REQ-026 Reset mid-operation discards queued events; after reset the block issues no pulse while busy is still high from the synchronizer.

Structure
REQ-027 A shared package holds the state enumeration and the default CNT_W and TMO constants.
REQ-028 The block is a single module with no sub-modules; the up/down saturating counter stays inline.

Verification
REQ-029 Single event_in at cycle 0, busy held 0 -> sinput high in cycle 2 only; pending goes 0,1,0.
REQ-030 3 back-to-back events; bench asserts busy 1 cycle after each sinput and holds it 5 cycles -> exactly 3 sinput pulses, each gap at least 6 cycles; pending ends 0.
REQ-031 CNT_W=4 with busy stuck 1 and 16 events -> pending=15 and overflow=1; ovf_clr -> overflow=0 and pending stays 15.
REQ-032 busy never rises after a pulse, TMO=4 -> tmo_err=1 four cycles after WAIT_HI is entered; FSM returns to IDLE; the next queued event is issued.
REQ-033 event_in on the same edge as the ISSUE decrement with pending=2 -> pending stays 2.
REQ-034 rstA asserted during WAIT_LO with pending=5 -> pending 0, idle 1, no sinput while busy remains high.

Source files
------------

// File: rtl/pulse_req_queue_pkg.sv
// Shared definitions for the pulse request queue: handshake state encoding
// and the default counter width / busy-rise timeout.
package pulse_req_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } reqState_t;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_TMO   = 4;

    // Timeout counter width; covers the full 1..255 timeout range.
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/pulse_req_queue.sv
// Pulse request queue: counts single-cycle source events and releases them
// one at a time as registered request pulses to a handshake pulse
// synchronizer. Each pulse waits for busy to rise then fall before the next
// one is issued. A busy that never rises is caught by a timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no handshake in flight; issue when pending>0 and busy low
// ISSUE   | request pulse is high for this single cycle
// WAIT_HI | waiting for busy to rise; timeout counter running
// WAIT_LO | busy seen high; waiting for it to fall
module pulse_req_queue
    import pulse_req_queue_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO   = DEF_TMO
) (
    input  logic             src_clkA,
    input  logic             rstA,
    input  logic             event_in,
    input  logic             busy,
    input  logic             ovf_clr,
    output logic             sinput,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             tmo_err,
    output logic             idle
);

    localparam logic [CNT_W-1:0]     PEND_MAX = '1;
    // Loaded on the way into WAIT_HI; reaching zero with busy still low
    // marks the TMO-th cycle spent in WAIT_HI.
    localparam logic [TMO_CNT_W-1:0] TMO_LOAD = TMO_CNT_W'(TMO - 1);

    reqState_t             stateQ;
    reqState_t             stateD;
    logic [CNT_W-1:0]      pendQ;
    logic [CNT_W-1:0]      pendD;
    logic [TMO_CNT_W-1:0]  tmoCntQ;
    logic [TMO_CNT_W-1:0]  tmoCntD;
    logic                  sinputQ;
    logic                  ovfQ;
    logic                  ovfD;
    logic                  tmoErrQ;
    logic                  tmoErrD;

    logic                  issueGo;
    logic                  tmoHit;
    logic                  pendFull;
    logic                  incAccept;
    logic                  ovfSet;

    // Next-state decode for the handshake FSM and its timeout down-counter.
    always_comb begin
        stateD  = stateQ;
        tmoCntD = tmoCntQ;
        issueGo = 1'b0;
        tmoHit  = 1'b0;
        case (stateQ)
            IDLE: begin
                if ((pendQ != '0) && !busy) begin
                    issueGo = 1'b1;
                    stateD  = ISSUE;
                end
            end
            ISSUE: begin
                stateD  = WAIT_HI;
                tmoCntD = TMO_LOAD;
            end
            WAIT_HI: begin
                if (busy) begin
                    stateD  = WAIT_LO;
                    tmoCntD = '0;
                end else if (tmoCntQ == '0) begin
                    tmoHit = 1'b1;
                    stateD = IDLE;
                end else begin
                    tmoCntD = tmoCntQ - 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD  = IDLE;
                tmoCntD = '0;
            end
        endcase
    end

    // Saturating up/down pending counter with overflow detection. The
    // decrement (issueGo) only happens with pending>0, so it cannot wrap
    // below zero; an increment into a full counter is accepted only when a
    // decrement frees a slot on the same edge.
    always_comb begin
        pendFull  = (pendQ == PEND_MAX);
        incAccept = event_in && (!pendFull || issueGo);
        ovfSet    = event_in && pendFull && !issueGo;
        pendD     = pendQ;
        case ({incAccept, issueGo})
            2'b10:   pendD = pendQ + 1'b1;
            2'b01:   pendD = pendQ - 1'b1;
            default: pendD = pendQ;
        endcase
        // A new drop outranks a clear arriving in the same cycle.
        if (ovfSet) begin
            ovfD = 1'b1;
        end else if (ovf_clr) begin
            ovfD = 1'b0;
        end else begin
            ovfD = ovfQ;
        end
        tmoErrD = tmoErrQ | tmoHit;
    end

    // State, counters, flags and the registered request pulse.
    always_ff @(posedge src_clkA) begin
        if (rstA) begin
            stateQ  <= IDLE;
            pendQ   <= '0;
            tmoCntQ <= '0;
            sinputQ <= 1'b0;
            ovfQ    <= 1'b0;
            tmoErrQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            pendQ   <= pendD;
            tmoCntQ <= tmoCntD;
            sinputQ <= (stateD == ISSUE);
            ovfQ    <= ovfD;
            tmoErrQ <= tmoErrD;
        end
    end

    assign sinput   = sinputQ;
    assign pending  = pendQ;
    assign overflow = ovfQ;
    assign tmo_err  = tmoErrQ;
    assign idle     = (stateQ == IDLE) && (pendQ == '0);

endmodule

// File: tb/tb_pulse_req_queue.sv
// Self-checking bench for pulse_req_queue: a directed vector table, a few
// hand-written corner sequences and a long randomized run, all checked
// against a behavioural model of the queue and handshake.
module tb_pulse_req_queue;

    localparam int CNT_W    = 4;
    localparam int TMO      = 4;
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    localparam int PH_QUIET   = 0;
    localparam int PH_PULSE   = 1;
    localparam int PH_AWAIT   = 2;
    localparam int PH_RELEASE = 3;

    logic             src_clkA = 1'b0;
    logic             rstA     = 1'b1;
    logic             event_in = 1'b0;
    logic             busy     = 1'b0;
    logic             ovf_clr  = 1'b0;
    logic             sinput;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             tmo_err;
    logic             idle;

    int vecCount  = 0;
    int missCount = 0;
    int cycNum    = 0;

    // Behavioural model: a plain event count plus the handshake phase.
    int mPhase    = PH_QUIET;
    int mPend     = 0;
    int mHiCycles = 0;
    bit mOvf      = 1'b0;
    bit mTmo      = 1'b0;

    typedef struct {
        bit ev;
        bit bz;
        bit clr;
        bit rs;
        bit eSin;
        int ePend;
        bit eOvf;
        bit eTmo;
        bit eIdle;
    } vec_t;

    vec_t tbl[15];

    pulse_req_queue #(
        .CNT_W(CNT_W),
        .TMO  (TMO)
    ) dut (
        .src_clkA(src_clkA),
        .rstA    (rstA),
        .event_in(event_in),
        .busy    (busy),
        .ovf_clr (ovf_clr),
        .sinput  (sinput),
        .pending (pending),
        .overflow(overflow),
        .tmo_err (tmo_err),
        .idle    (idle)
    );

    always #5 src_clkA = ~src_clkA;

    // Advance the model by one clock edge given that cycle's inputs.
    task automatic modelStep(input bit ev, input bit bz, input bit clr, input bit rs);
        bit issue;
        int nextPend;
        if (rs) begin
            mPhase    = PH_QUIET;
            mPend     = 0;
            mHiCycles = 0;
            mOvf      = 1'b0;
            mTmo      = 1'b0;
        end else begin
            issue    = (mPhase == PH_QUIET) && (mPend > 0) && !bz;
            nextPend = mPend + int'(ev) - int'(issue);
            if (nextPend > PEND_MAX) begin
                nextPend = PEND_MAX;
                mOvf     = 1'b1;
            end else if (clr) begin
                mOvf = 1'b0;
            end
            case (mPhase)
                PH_QUIET:   if (issue) mPhase = PH_PULSE;
                PH_PULSE: begin
                    mPhase    = PH_AWAIT;
                    mHiCycles = 0;
                end
                PH_AWAIT: begin
                    if (bz) begin
                        mPhase = PH_RELEASE;
                    end else begin
                        mHiCycles++;
                        if (mHiCycles == TMO) begin
                            mTmo   = 1'b1;
                            mPhase = PH_QUIET;
                        end
                    end
                end
                default:    if (!bz) mPhase = PH_QUIET;
            endcase
            mPend = nextPend;
        end
    endtask

    task automatic checkModel();
        int eSin;
        int eIdle;
        eSin  = (mPhase == PH_PULSE) ? 1 : 0;
        eIdle = (mPhase == PH_QUIET && mPend == 0) ? 1 : 0;
        vecCount++;
        if (int'(sinput) != eSin || int'(pending) != mPend || overflow != mOvf ||
            tmo_err != mTmo || int'(idle) != eIdle) begin
            missCount++;
            $display("FAIL model cyc=%0d sin/pend/ovf/tmo/idle act=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
                     cycNum, sinput, pending, overflow, tmo_err, idle,
                     eSin, mPend, mOvf, mTmo, eIdle);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("FAIL %s cyc=%0d act=%0d exp=%0d", name, cycNum, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check the outputs.
    task automatic step(input bit ev, input bit bz, input bit clr, input bit rs);
        event_in = ev;
        busy     = bz;
        ovf_clr  = clr;
        rstA     = rs;
        @(posedge src_clkA);
        modelStep(ev, bz, clr, rs);
        #1;
        cycNum++;
        checkModel();
    endtask

    initial begin
        int pulses;
        int lastPulse;
        int minGap;
        int busyLeft;
        int sinSeen;
        bit ev;
        bit bz;
        bit clr;
        bit rs;
        bit stuck;

        //             ev bz clr rs | sin pend ovf tmo idle
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};

        // Directed table: single-event latency, full handshake, timeout
        // after four WAIT_HI cycles with re-issue, then reset.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ev, tbl[i].bz, tbl[i].clr, tbl[i].rs);
            vecCount++;
            if (sinput != tbl[i].eSin || int'(pending) != tbl[i].ePend ||
                overflow != tbl[i].eOvf || tmo_err != tbl[i].eTmo || idle != tbl[i].eIdle) begin
                missCount++;
                $display("FAIL table[%0d] sin/pend/ovf/tmo/idle act=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
                         i, sinput, pending, overflow, tmo_err, idle,
                         tbl[i].eSin, tbl[i].ePend, tbl[i].eOvf, tbl[i].eTmo, tbl[i].eIdle);
            end
        end

        // Three back-to-back events against a responder holding busy 5 cycles.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pulses    = 0;
        lastPulse = -1;
        minGap    = 1000;
        busyLeft  = 0;
        for (int c = 0; c < 60; c++) begin
            bz = (busyLeft > 0);
            if (busyLeft > 0) busyLeft--;
            step(c < 3, bz, 1'b0, 1'b0);
            if (sinput) begin
                pulses++;
                if (lastPulse >= 0 && (c - lastPulse) < minGap) minGap = c - lastPulse;
                lastPulse = c;
                busyLeft  = 5;
            end
        end
        checkVal("burst_pulses", pulses, 3);
        checkVal("burst_gap_ge6", (minGap >= 6) ? 1 : 0, 1);
        checkVal("burst_pend_end", int'(pending), 0);

        // Fill with busy stuck high, drop the 16th event, clear overflow,
        // full+decrement, then set-vs-clear in one cycle.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("full_pend", int'(pending), 15);
        checkVal("full_ovf", int'(overflow), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("clr_ovf", int'(overflow), 0);
        checkVal("clr_pend", int'(pending), 15);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("fulldec_pend", int'(pending), 15);
        checkVal("fulldec_ovf", int'(overflow), 0);
        checkVal("fulldec_sin", int'(sinput), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checkVal("setwins_ovf", int'(overflow), 1);
        checkVal("setwins_pend", int'(pending), 15);

        // Event on the same edge as the decrement with pending=2.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("simul_pre", int'(pending), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("simul_pend", int'(pending), 2);
        checkVal("simul_sin", int'(sinput), 1);

        // Reset during WAIT_LO with pending=5 while busy stays high.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("waitlo_pend", int'(pending), 5);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("rst_pend", int'(pending), 0);
        checkVal("rst_idle", int'(idle), 1);
        sinSeen = 0;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 1'b1, 1'b0, 1'b0);
            sinSeen += int'(sinput);
        end
        checkVal("rst_busy_nopulse", sinSeen, 0);

        // Randomized run against the model, including stuck-busy stretches
        // to reach the full/overflow region and occasional resets.
        bz = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            stuck = (((c / 80) % 3) == 2);
            ev    = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            rs    = ($urandom_range(0, 299) == 0);
            if (stuck) bz = 1'b1;
            else if ($urandom_range(0, 3) == 0) bz = ~bz;
            step(ev, bz, clr, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
